// File: rtl/data_mem_responder_pkg.sv
// Shared types for the data-memory responder.
// FSM encoding and default write-buffer depth.
package data_mem_responder_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WR_WAIT = 2'd1,
        RD_WAIT = 2'd2,
        RD_DONE = 2'd3
    } state_e;

    localparam int WB_DEPTH_DEF = 4;

endpackage

// File: rtl/data_mem_responder_if.sv
// Core-side data port plus backing-memory handshake.
// slave = responder view, master = core/memory environment view.
interface data_mem_responder_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              cpu_en;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_stall;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  cpu_en, cpu_we, cpu_addr, cpu_wdata, mem_ack, mem_rdata,
        output cpu_rdata, cpu_stall, mem_req, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output cpu_en, cpu_we, cpu_addr, cpu_wdata, mem_ack, mem_rdata,
        input  cpu_rdata, cpu_stall, mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/data_mem_responder_wb_fifo.sv
// In-order posted-write buffer with youngest-match lookup.
// The head stays visible to lookup until it is popped.
module data_mem_responder_wb_fifo
    import data_mem_responder_pkg::*;
#(
    parameter int DEPTH = WB_DEPTH_DEF,
    parameter int AW    = 30,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_i,
    input  logic [AW-1:0] push_addr_i,
    input  logic [DW-1:0] push_data_i,
    input  logic          pop_i,
    input  logic [AW-1:0] look_addr_i,
    output logic          look_hit_o,
    output logic [DW-1:0] look_data_o,
    output logic [AW-1:0] head_addr_o,
    output logic [DW-1:0] head_data_o,
    output logic          full_o,
    output logic          empty_o
);
    localparam int PW = $clog2(DEPTH);

    logic [AW-1:0] addr_q [DEPTH];
    logic [DW-1:0] data_q [DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [PW:0]   cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
            cnt_q <= cnt_q + (PW+1)'(push_i) - (PW+1)'(pop_i);
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) begin
            addr_q[wr_ptr_q] <= push_addr_i;
            data_q[wr_ptr_q] <= push_data_i;
        end
    end

    // Scan oldest to youngest so the last match wins.
    always_comb begin
        look_hit_o  = 1'b0;
        look_data_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if ((PW+1)'(i) < cnt_q &&
                addr_q[rd_ptr_q + PW'(i)] == look_addr_i) begin
                look_hit_o  = 1'b1;
                look_data_o = data_q[rd_ptr_q + PW'(i)];
            end
        end
    end

    assign head_addr_o = addr_q[rd_ptr_q];
    assign head_data_o = data_q[rd_ptr_q];
    assign full_o      = (cnt_q == (PW+1)'(DEPTH));
    assign empty_o     = (cnt_q == '0);

endmodule

// File: rtl/data_mem_responder.sv
// Data-port responder: posted write buffer, load forwarding,
// and a single-outstanding backing-memory request FSM.
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int WB_DEPTH = WB_DEPTH_DEF,
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    data_mem_responder_if.slave  bus,
    output logic                 wb_empty
);
    localparam int AW = ADDR_W - 2;

    state_e            st_q, st_d;
    logic [ADDR_W-1:0] maddr_q, maddr_d;
    logic [DATA_W-1:0] mwdata_q, mwdata_d;
    logic [DATA_W-1:0] rd_q, rd_d;
    logic [DATA_W-1:0] last_q, last_d;

    logic              is_ld, is_st, miss, deq, enq;
    logic              hit, full, empty, stall;
    logic [DATA_W-1:0] hit_data, head_data, rdata;
    logic [AW-1:0]     head_addr;
    logic              unused_lsb;

    assign unused_lsb = ^bus.cpu_addr[1:0];

    data_mem_responder_wb_fifo #(
        .DEPTH (WB_DEPTH),
        .AW    (AW),
        .DW    (DATA_W)
    ) u_wb (
        .clk         (clk),
        .rst         (rst),
        .push_i      (enq),
        .push_addr_i (bus.cpu_addr[ADDR_W-1:2]),
        .push_data_i (bus.cpu_wdata),
        .pop_i       (deq),
        .look_addr_i (bus.cpu_addr[ADDR_W-1:2]),
        .look_hit_o  (hit),
        .look_data_o (hit_data),
        .head_addr_o (head_addr),
        .head_data_o (head_data),
        .full_o      (full),
        .empty_o     (empty)
    );

    assign is_ld = bus.cpu_en & ~bus.cpu_we;
    assign is_st = bus.cpu_en &  bus.cpu_we;
    assign miss  = is_ld & ~hit;
    assign deq   = (st_q == WR_WAIT) & bus.mem_ack;
    // A slot freed this edge can take the stalled store.
    assign enq   = is_st & (~full | deq);

    always_comb begin
        st_d     = st_q;
        maddr_d  = maddr_q;
        mwdata_d = mwdata_q;
        rd_d     = rd_q;
        unique case (st_q)
            IDLE: begin
                if (miss) begin
                    st_d    = RD_WAIT;
                    maddr_d = {bus.cpu_addr[ADDR_W-1:2], 2'b00};
                end else if (!empty) begin
                    st_d     = WR_WAIT;
                    maddr_d  = {head_addr, 2'b00};
                    mwdata_d = head_data;
                end
            end
            WR_WAIT: if (bus.mem_ack) st_d = IDLE;
            RD_WAIT: begin
                if (bus.mem_ack) begin
                    st_d = RD_DONE;
                    rd_d = bus.mem_rdata;
                end
            end
            RD_DONE: st_d = IDLE;
            default: st_d = IDLE;
        endcase
    end

    always_comb begin
        stall = (is_st & full & ~deq) | (miss & (st_q != RD_DONE));
        if (st_q == RD_DONE)  rdata = rd_q;
        else if (is_ld & hit) rdata = hit_data;
        else                  rdata = last_q;
        last_d = (is_ld & ~stall) ? rdata : last_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st_q     <= IDLE;
            maddr_q  <= '0;
            mwdata_q <= '0;
            rd_q     <= '0;
            last_q   <= '0;
        end else begin
            st_q     <= st_d;
            maddr_q  <= maddr_d;
            mwdata_q <= mwdata_d;
            rd_q     <= rd_d;
            last_q   <= last_d;
        end
    end

    assign bus.cpu_stall = stall;
    assign bus.cpu_rdata = rdata;
    assign bus.mem_req   = (st_q == WR_WAIT) | (st_q == RD_WAIT);
    assign bus.mem_we    = (st_q == WR_WAIT);
    assign bus.mem_addr  = maddr_q;
    assign bus.mem_wdata = mwdata_q;
    assign wb_empty      = empty;

endmodule
